// File: rtl/pong_game_ctrl_if.sv
// Key/vsync inputs and registered game-state outputs of the Pong game controller.
interface pong_game_ctrl_if;
    logic [7:0] key_code_i;
    logic       key_valid_i;
    logic       frame_i;
    logic [9:0] paddle_x_o;
    logic [9:0] ball_x_o;
    logic [9:0] ball_y_o;
    logic [7:0] score_o;
    logic [1:0] lives_o;
    logic [1:0] state_o;

    modport master (
        output key_code_i, key_valid_i, frame_i,
        input  paddle_x_o, ball_x_o, ball_y_o, score_o, lives_o, state_o
    );

    modport slave (
        input  key_code_i, key_valid_i, frame_i,
        output paddle_x_o, ball_x_o, ball_y_o, score_o, lives_o, state_o
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Frame-synchronous Pong controller: PS/2 key tracking, paddle/ball motion,
// serve sequencing, score and lives; game state advances once per vsync rise.
module pong_game_ctrl #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned PADDLE_W     = 64,
    parameter int unsigned PADDLE_H     = 16,
    parameter int unsigned BALL_R       = 8,
    parameter int unsigned PADDLE_STEP  = 4,
    parameter int unsigned BALL_STEP    = 2,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    pong_game_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [9:0] PADDLE_HOME = 10'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [9:0] PADDLE_MAX  = 10'(SCREEN_W - PADDLE_W);
    localparam logic [9:0] P_STEP      = 10'(PADDLE_STEP);
    localparam logic [9:0] B_STEP      = 10'(BALL_STEP);
    localparam logic [9:0] B_R         = 10'(BALL_R);
    localparam logic [9:0] HOME_X      = 10'(SCREEN_W / 2);
    localparam logic [9:0] HOME_Y      = 10'd40;
    localparam logic [9:0] NEAR_EDGE   = 10'(BALL_R + BALL_STEP);
    localparam logic [9:0] RIGHT_LIM   = 10'(SCREEN_W - BALL_STEP);
    localparam logic [9:0] HIT_LO      = 10'(SCREEN_H - PADDLE_H - BALL_STEP);
    localparam logic [9:0] HIT_HI      = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0] BOTTOM      = 10'(SCREEN_H);
    localparam logic [9:0] PAD_REACH   = 10'(PADDLE_W + BALL_R);
    localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       paddle_q, paddle_d, bx_q, bx_d, by_q, by_d, paddle_mv;
    logic [7:0]       score_q, score_d;
    logic [1:0]       lives_q, lives_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
    logic             serve_neg_q, serve_neg_d, start_req_q, start_req_d;
    logic             vx_n, vy_n, hit, miss;
    logic             frame_q, ext_q, brk_q, held_left_q, held_right_q;
    logic             tick_c, plain_key_c;

    assign tick_c      = bus.frame_i & ~frame_q;
    assign plain_key_c = bus.key_valid_i && (bus.key_code_i != 8'hE0) && (bus.key_code_i != 8'hF0);

    // Scancode prefix tracking and held-key flags.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            frame_q      <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            held_left_q  <= 1'b0;
            held_right_q <= 1'b0;
        end else begin
            frame_q <= bus.frame_i;
            if (bus.key_valid_i) begin
                if (bus.key_code_i == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (bus.key_code_i == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    if (!ext_q && bus.key_code_i == 8'h1C) held_left_q  <= ~brk_q;
                    if (!ext_q && bus.key_code_i == 8'h23) held_right_q <= ~brk_q;
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            paddle_q    <= PADDLE_HOME;
            bx_q        <= HOME_X;
            by_q        <= HOME_Y;
            score_q     <= 8'd0;
            lives_q     <= LIVES_INIT;
            cnt_q       <= '0;
            vx_neg_q    <= 1'b0;
            vy_neg_q    <= 1'b0;
            serve_neg_q <= 1'b0;
            start_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddle_q    <= paddle_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            vx_neg_q    <= vx_neg_d;
            vy_neg_q    <= vy_neg_d;
            serve_neg_q <= serve_neg_d;
            start_req_q <= start_req_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        paddle_d    = paddle_q;
        bx_d        = bx_q;
        by_d        = by_q;
        score_d     = score_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        vx_neg_d    = vx_neg_q;
        vy_neg_d    = vy_neg_q;
        serve_neg_d = serve_neg_q;
        start_req_d = start_req_q;
        vx_n        = vx_neg_q;
        vy_n        = vy_neg_q;
        hit         = 1'b0;
        miss        = 1'b0;
        paddle_mv   = paddle_q;

        if (held_left_q && !held_right_q)
            paddle_mv = (paddle_q <= P_STEP) ? 10'd0 : paddle_q - P_STEP;
        else if (held_right_q && !held_left_q)
            paddle_mv = (paddle_q >= PADDLE_MAX - P_STEP) ? PADDLE_MAX : paddle_q + P_STEP;

        if (state_q == ST_IDLE) begin
            paddle_d = PADDLE_HOME;
            bx_d     = HOME_X;
            by_d     = HOME_Y;
        end

        if (tick_c) begin
            unique case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_req_q) begin
                        start_req_d = 1'b0;
                        score_d     = 8'd0;
                        lives_d     = LIVES_INIT;
                        vx_neg_d    = 1'b0;
                        serve_neg_d = 1'b1;
                        vy_neg_d    = 1'b0;
                        bx_d        = HOME_X;
                        by_d        = HOME_Y;
                        cnt_d       = SERVE_LOAD;
                        state_d     = ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    start_req_d = 1'b0;
                    paddle_d    = paddle_mv;
                    if (cnt_q == '0) state_d = ST_PLAY;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_PLAY: begin
                    start_req_d = 1'b0;
                    paddle_d    = paddle_mv;
                    if (bx_q <= NEAR_EDGE)        vx_n = 1'b0;
                    if (bx_q + B_R >= RIGHT_LIM)  vx_n = 1'b1;
                    if (by_q <= NEAR_EDGE)        vy_n = 1'b0;
                    hit  = !vy_n && (by_q + B_R >= HIT_LO) && (by_q + B_R <= HIT_HI) &&
                           (paddle_q <= bx_q + B_R) && (bx_q < paddle_q + PAD_REACH);
                    miss = !hit && !vy_n && (by_q + B_R >= BOTTOM);
                    if (hit) begin
                        vy_n    = 1'b1;
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    end
                    vx_neg_d = vx_n;
                    vy_neg_d = vy_n;
                    if (miss) begin
                        lives_d = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_d = ST_OVER;
                        end else begin
                            // Re-serve from the top, alternating horizontal direction.
                            vx_neg_d    = serve_neg_q;
                            serve_neg_d = ~serve_neg_q;
                            vy_neg_d    = 1'b0;
                            bx_d        = HOME_X;
                            by_d        = HOME_Y;
                            cnt_d       = SERVE_LOAD;
                            state_d     = ST_SERVE;
                        end
                    end else begin
                        bx_d = vx_n ? bx_q - B_STEP : bx_q + B_STEP;
                        by_d = vy_n ? by_q - B_STEP : by_q + B_STEP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A start byte landing on a tick cycle still registers for the next tick.
        if (plain_key_c && !ext_q && !brk_q && bus.key_code_i == 8'h29)
            start_req_d = 1'b1;
    end

    assign bus.paddle_x_o = paddle_q;
    assign bus.ball_x_o   = bx_q;
    assign bus.ball_y_o   = by_q;
    assign bus.score_o    = score_q;
    assign bus.lives_o    = lives_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed testbench for pong_game_ctrl with hand-computed expected positions.
module tb_pong_game_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic send_key(input logic [7:0] code);
        @(negedge clk);
        bus.key_code_i  = code;
        bus.key_valid_i = 1'b1;
        @(negedge clk);
        bus.key_valid_i = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.frame_i = 1'b1;
            repeat (2) @(negedge clk);
            bus.frame_i = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        check({tag, "_x"}, 32'(bus.ball_x_o), 32'(x));
        check({tag, "_y"}, 32'(bus.ball_y_o), 32'(y));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},  32'(bus.state_o), 0);
        check({tag, "_paddle"}, 32'(bus.paddle_x_o), 288);
        check_ball(tag, 320, 40);
        check({tag, "_score"},  32'(bus.score_o), 0);
        check({tag, "_lives"},  32'(bus.lives_o), 3);
    endtask

    task automatic wait_state(input string tag, input int target, input int budget);
        int k = 0;
        while (32'(bus.state_o) != 32'(target) && k < budget) begin
            ticks(1);
            k++;
        end
        check(tag, 32'(bus.state_o), 32'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.key_code_i  = 8'h00;
        bus.key_valid_i = 1'b0;
        bus.frame_i     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rstn = 1'b1;

        ticks(5);
        check_reset_vals("idle5");

        // Held right in IDLE does not move the paddle.
        send_key(8'h23);
        ticks(3);
        check("idle_hold_paddle", 32'(bus.paddle_x_o), 288);

        send_key(8'h29);
        ticks(1);
        check("start_state", 32'(bus.state_o), 1);
        check("start_paddle", 32'(bus.paddle_x_o), 288);

        ticks(10);
        check("right10", 32'(bus.paddle_x_o), 328);
        send_key(8'hF0);
        send_key(8'h23);
        ticks(3);
        check("right_break", 32'(bus.paddle_x_o), 328);
        check("serve_state", 32'(bus.state_o), 1);

        send_key(8'h1C);
        ticks(46);
        check("serve59_paddle", 32'(bus.paddle_x_o), 144);
        check("serve59_state", 32'(bus.state_o), 1);
        check_ball("serve59", 320, 40);
        ticks(1);
        check("play_enter", 32'(bus.state_o), 2);
        check_ball("play_enter", 320, 40);
        ticks(1);
        check_ball("play1", 322, 42);
        check("play1_paddle", 32'(bus.paddle_x_o), 136);
        ticks(99);
        check("left_sat", 32'(bus.paddle_x_o), 0);
        check_ball("play100", 520, 240);

        send_key(8'hF0);
        send_key(8'h1C);
        ticks(55);
        check_ball("right_wall", 630, 350);
        check("left_break", 32'(bus.paddle_x_o), 0);
        ticks(1);
        check_ball("bounce", 628, 352);
        ticks(60);
        check_ball("pre_miss", 508, 472);
        check("pre_miss_state", 32'(bus.state_o), 2);
        ticks(1);
        check("miss1_lives", 32'(bus.lives_o), 2);
        check("miss1_state", 32'(bus.state_o), 1);

        // Second serve: park the paddle at 80 so the descending ball is caught.
        send_key(8'h23);
        ticks(20);
        send_key(8'hF0);
        send_key(8'h23);
        ticks(40);
        check("serve2_play", 32'(bus.state_o), 2);
        check("serve2_paddle", 32'(bus.paddle_x_o), 80);
        check_ball("serve2_enter", 320, 40);
        ticks(1);
        check_ball("serve2_vxneg", 318, 42);
        ticks(206);
        check_ball("pre_hit", 114, 454);
        check("pre_hit_score", 32'(bus.score_o), 0);
        ticks(1);
        check_ball("hit", 116, 452);
        check("hit_score", 32'(bus.score_o), 1);

        wait_state("miss2_state", 1, 1000);
        check("miss2_lives", 32'(bus.lives_o), 1);
        wait_state("over_state", 3, 1000);
        check("over_lives", 32'(bus.lives_o), 0);
        check_ball("over", 508, 472);
        ticks(5);
        check_ball("frozen", 508, 472);
        check("frozen_paddle", 32'(bus.paddle_x_o), 80);
        check("frozen_score", 32'(bus.score_o), 1);
        check("frozen_state", 32'(bus.state_o), 3);

        // Extended 1C must not register as left; the following 29 still starts.
        send_key(8'hE0);
        send_key(8'h1C);
        send_key(8'h29);
        ticks(1);
        check("restart_state", 32'(bus.state_o), 1);
        check("restart_score", 32'(bus.score_o), 0);
        check("restart_lives", 32'(bus.lives_o), 3);
        ticks(1);
        check("ext_ignored", 32'(bus.paddle_x_o), 80);
        ticks(59);
        check("restart_play", 32'(bus.state_o), 2);
        ticks(1);
        check_ball("restart_vxpos", 322, 42);

        // Reset wins over a simultaneous tick and start byte.
        @(negedge clk);
        rstn            = 1'b0;
        bus.frame_i     = 1'b1;
        bus.key_code_i  = 8'h29;
        bus.key_valid_i = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rstn            = 1'b1;
        bus.frame_i     = 1'b0;
        bus.key_valid_i = 1'b0;
        ticks(2);
        check("post_rst_idle", 32'(bus.state_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
